instr_mem_resp: RTL
===================

INSTR_MEM_RESP -- requirements
Module: instr_mem_resp

Interface
REQ-001: Parameter N, default 32, data/address width in bits.
REQ-002: Parameter DEPTH, default 64, number of instruction words stored; SHALL be a power of 2, range 4..1024.
REQ-003: Parameter LATENCY, default 2, cycles from request acceptance to response valid; legal range 1..7.
REQ-004: clk  input  1  single clock; all state updates on rising edge.
REQ-005: reset_n  input  1  asynchronous, active-low reset.
REQ-006: req_valid  input  1  fetch request present (driven by PC side).
REQ-007: req_addr  input  N  byte address of the instruction (the pc value).
REQ-008: req_ready  output  1  block can accept a request this cycle.
REQ-009: rsp_valid  output  1  rsp_instr/rsp_err are valid.
REQ-010: rsp_ready  input  1  consumer accepts the response.
REQ-011: rsp_instr  output  N  fetched instruction word.
REQ-012: rsp_err  output  1  fetch fault (misaligned or out of range).
REQ-013: wr_en  input  1  boot-load write strobe.
REQ-014: wr_addr  input  N  byte address of boot-load write; bits [1:0] ignored.
REQ-015: wr_data  input  N  boot-load write data.

Function
REQ-016: The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-017: req_ready SHALL be 1 only in IDLE; rsp_valid SHALL be 1 only in RESP.
REQ-018: A request is accepted on the rising edge where req_valid=1 and req_ready=1; req_addr is latched, a down-counter is loaded with LATENCY-1, and the state becomes WAIT.
REQ-019: In WAIT, the counter decrements each cycle; on the edge where it equals 0, the state becomes RESP, and rsp_instr and rsp_err are registered from the latched address.
REQ-020: rsp_valid SHALL rise exactly LATENCY clock edges after the accepting edge.
REQ-021: In RESP, rsp_instr and rsp_err SHALL be held stable until the edge with rsp_ready=1; on that edge the state SHALL return to IDLE.
REQ-022: There is no back-to-back pipelining, so a new request is accepted no earlier than the cycle after the response handshake.
REQ-023: The word index is req_addr[N-1:2].
REQ-024: A write with wr_en=1 updates the word at wr_addr[N-1:2] on the rising edge; writes are accepted in any state.
REQ-025: If the write and the WAIT->RESP read hit the same word on the same edge, the read SHALL return the old contents.
REQ-026: A write whose index is >= DEPTH SHALL be ignored.
REQ-027: When rsp_err=1, rsp_instr SHALL be 0 (NOP).

Reset
REQ-028: When reset_n=0, the state SHALL immediately go to IDLE, with counter=0, rsp_valid=0, rsp_instr=0, rsp_err=0, and req_ready=1 once reset_n=1.
REQ-029: A reset during WAIT or RESP SHALL drop the in-flight transaction with no response.
REQ-030: Memory contents SHALL NOT be reset.

Configuration
REQ-031: With macro IMEM_ERR_CHECK_EN defined, rsp_err=1 when latched addr[1:0]!=0 or the word index is >= DEPTH.
REQ-032: Without IMEM_ERR_CHECK_EN, rsp_err SHALL be tied to 0, addr[1:0] is ignored, and the index wraps modulo DEPTH.

Structure
REQ-033: Shared package mips_pkg SHALL hold the WORD_W=32 constant, the NOP word 32'h0000_0000, and the FSM state encoding typedef.
REQ-034: Storage SHALL be a sub-module imem_array with one synchronous write port and one read port, read-before-write; instr_mem_resp instantiates it once.

Verification
REQ-035: Load word 3 = 32'h2008_0005 via wr_en; request addr 32'h0000_000C, LATENCY=2 -> rsp_valid rises 2 edges after acceptance with rsp_instr=32'h2008_0005 and rsp_err=0.
REQ-036: Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_instr stable and req_ready=0 throughout; rsp_ready=1 -> IDLE the next cycle.
REQ-037: With IMEM_ERR_CHECK_EN, request addr 32'h0000_0006 -> rsp_err=1 and rsp_instr=0; request addr 4*DEPTH -> rsp_err=1. Without the macro, addr 4*DEPTH -> word 0 returned and rsp_err=0.
REQ-038: Write word 5 with 32'hAAAA_AAAA on the same edge WAIT->RESP reads word 5 (old value 32'h1111_1111) -> response is 32'h1111_1111; a subsequent fetch returns 32'hAAAA_AAAA.
REQ-039: Assert reset_n=0 mid-WAIT -> rsp_valid is never asserted for that request, all outputs are 0, and req_ready=1 after release; memory contents are preserved.
REQ-040: With LATENCY=1 and LATENCY=7, sweep 20 random aligned fetches -> latency is exactly 1 and 7 respectively and the data matches the model.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared word width, NOP encoding and fetch FSM state type
package mips_pkg;
    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] NOP = 32'h0000_0000;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/imem_array.sv
// imem_array: instruction storage with one synchronous write port and one combinational read port
module imem_array #(
    parameter int W     = 32,
    parameter int DEPTH = 64,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [W-1:0]  wr_data,
    input  logic [IW-1:0] rd_idx,
    output logic [W-1:0]  rd_data
);
    logic [W-1:0] mem [DEPTH];
    // write port; a register sampling rd_data on this same edge still captures the old word
    always_ff @(posedge clk)
        if (wr_en) mem[wr_idx] <= wr_data;
    assign rd_data = mem[rd_idx];
endmodule

// File: rtl/instr_mem_resp.sv
// instr_mem_resp: instruction memory with fixed-latency valid/ready fetch response and boot-load write port
// Optional fault detection (misaligned / out-of-range fetch) is enabled by defining IMEM_ERR_CHECK_EN.
module instr_mem_resp
    import mips_pkg::*;
#(
    parameter int N       = WORD_W,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req_valid,
    input  logic [N-1:0] req_addr,
    output logic         req_ready,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_instr,
    output logic         rsp_err,
    input  logic         wr_en,
    input  logic [N-1:0] wr_addr,
    input  logic [N-1:0] wr_data
);
    localparam int IW = $clog2(DEPTH);

    state_t       state, state_nx;
    logic [2:0]   cnt;
    logic [N-1:0] addr_q;
    logic [N-1:0] rd_data;
    logic [N-3:0] wr_word, rd_word;
    logic         wr_ok, rd_err, unused_bits;

    assign wr_word     = wr_addr[N-1:2];
    assign rd_word     = addr_q[N-1:2];
    assign wr_ok       = (wr_word >> IW) == '0;
    assign unused_bits = ^{wr_addr[1:0], addr_q};

`ifdef IMEM_ERR_CHECK_EN
    assign rd_err = (addr_q[1:0] != 2'b00) || ((rd_word >> IW) != '0);
`else
    assign rd_err = 1'b0;
`endif

    imem_array #(.W(N), .DEPTH(DEPTH)) u_array (
        .clk    (clk),
        .wr_en  (wr_en && wr_ok),
        .wr_idx (wr_word[IW-1:0]),
        .wr_data(wr_data),
        .rd_idx (rd_word[IW-1:0]),
        .rd_data(rd_data)
    );

    // state register
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_nx;

    // next state and handshake outputs
    always_comb begin
        req_ready = state == IDLE;
        rsp_valid = state == RESP;
        state_nx  = (state == IDLE && req_valid) ? WAIT :
                    (state == WAIT && cnt == 3'd0) ? RESP :
                    (state == RESP && rsp_ready) ? IDLE : state;
    end

    // latch the fetch address, run the latency counter and capture the response
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            cnt       <= 3'd0;
            addr_q    <= '0;
            rsp_instr <= N'(NOP);
            rsp_err   <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                addr_q <= req_addr;
                cnt    <= 3'(LATENCY - 1);
            end else if (state == WAIT && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
            if (state == WAIT && cnt == 3'd0) begin
                rsp_err   <= rd_err;
                rsp_instr <= rd_err ? N'(NOP) : rd_data;
            end
        end
endmodule
